// File: rtl/afu_axil_ctrl.sv
// AXI4-Lite control slave for an XRT AFU: ap_ctrl_hs registers, GIE/IER/ISR, capability words and DCR write forwarding.
// Optional build macro AFU_CTRL_DCR_READY_EN adds a dcr_wr_ready handshake that back-pressures the write channel.
module afu_axil_ctrl #(
  parameter int unsigned AXI_ADDR_WIDTH = 8,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [63:0] DEV_CAPS       = 64'h0,
  parameter logic [63:0] ISA_CAPS       = 64'h0
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          s_axi_ctrl_awvalid,
  output logic                          s_axi_ctrl_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ctrl_awaddr,
  input  logic                          s_axi_ctrl_wvalid,
  output logic                          s_axi_ctrl_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_ctrl_wstrb,
  output logic                          s_axi_ctrl_bvalid,
  input  logic                          s_axi_ctrl_bready,
  output logic [1:0]                    s_axi_ctrl_bresp,
  input  logic                          s_axi_ctrl_arvalid,
  output logic                          s_axi_ctrl_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_ctrl_araddr,
  output logic                          s_axi_ctrl_rvalid,
  input  logic                          s_axi_ctrl_rready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_ctrl_rdata,
  output logic [1:0]                    s_axi_ctrl_rresp,
  output logic                          ap_start,
  input  logic                          ap_done,
  input  logic                          ap_ready,
  input  logic                          ap_idle,
  output logic                          dcr_wr_valid,
  output logic [31:0]                   dcr_wr_addr,
  output logic [31:0]                   dcr_wr_data,
`ifdef AFU_CTRL_DCR_READY_EN
  input  logic                          dcr_wr_ready,
`endif
  output logic                          interrupt
);

  localparam int unsigned W = AXI_ADDR_WIDTH - 2;
  localparam logic [W-1:0] A_CTRL   = W'(8'h00 >> 2);
  localparam logic [W-1:0] A_GIE    = W'(8'h04 >> 2);
  localparam logic [W-1:0] A_IER    = W'(8'h08 >> 2);
  localparam logic [W-1:0] A_ISR    = W'(8'h0C >> 2);
  localparam logic [W-1:0] A_DEV_LO = W'(8'h10 >> 2);
  localparam logic [W-1:0] A_DEV_HI = W'(8'h14 >> 2);
  localparam logic [W-1:0] A_ISA_LO = W'(8'h18 >> 2);
  localparam logic [W-1:0] A_ISA_HI = W'(8'h1C >> 2);
  localparam logic [W-1:0] A_DCR_AD = W'(8'h20 >> 2);
  localparam logic [W-1:0] A_DCR_DT = W'(8'h24 >> 2);

  typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rd_state_t;

  wr_state_t   wr_state;
  rd_state_t   rd_state;
  logic [W-1:0] wr_word;
  logic [W-1:0] rd_word;

  logic        auto_restart;
  logic        done_bit;
  logic        ready_bit;
  logic        gie;
  logic [1:0]  ier;
  logic [1:0]  isr;
  logic [1:0]  isr_next;
  logic [31:0] dcr_addr;
  logic [31:0] wmask;
  logic [31:0] rd_mux;

  logic w_hs;
  logic ar_hs;
  logic wr_ctrl, wr_gie, wr_ier, wr_isr, wr_dcr_addr, wr_dcr_data;
  logic ctrl_rd;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0]};

  assign s_axi_ctrl_bresp = 2'b00;
  assign s_axi_ctrl_rresp = 2'b00;

  assign w_hs    = s_axi_ctrl_wvalid & s_axi_ctrl_wready;
  assign ar_hs   = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
  assign rd_word = s_axi_ctrl_araddr[AXI_ADDR_WIDTH-1:2];

  assign wr_ctrl     = w_hs && (wr_word == A_CTRL);
  assign wr_gie      = w_hs && (wr_word == A_GIE);
  assign wr_ier      = w_hs && (wr_word == A_IER);
  assign wr_isr      = w_hs && (wr_word == A_ISR);
  assign wr_dcr_addr = w_hs && (wr_word == A_DCR_AD);
  assign wr_dcr_data = w_hs && (wr_word == A_DCR_DT);
  assign ctrl_rd     = ar_hs && (rd_word == A_CTRL);

  assign wmask = {{8{s_axi_ctrl_wstrb[3]}}, {8{s_axi_ctrl_wstrb[2]}},
                  {8{s_axi_ctrl_wstrb[1]}}, {8{s_axi_ctrl_wstrb[0]}}};

  assign isr_next = (isr ^ (wr_isr ? (s_axi_ctrl_wdata[1:0] & {2{s_axi_ctrl_wstrb[0]}}) : 2'b00))
                  | {ap_ready & ier[1], ap_done & ier[0]};

  // Write channel FSM; handshake outputs are registered state bits.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state           <= WRRESET;
      wr_word            <= '0;
      s_axi_ctrl_awready <= 1'b0;
      s_axi_ctrl_wready  <= 1'b0;
      s_axi_ctrl_bvalid  <= 1'b0;
    end else begin
      case (wr_state)
        WRRESET: begin
          wr_state           <= WRIDLE;
          s_axi_ctrl_awready <= 1'b1;
        end
        WRIDLE: if (s_axi_ctrl_awvalid) begin
          wr_word            <= s_axi_ctrl_awaddr[AXI_ADDR_WIDTH-1:2];
          s_axi_ctrl_awready <= 1'b0;
          s_axi_ctrl_wready  <= 1'b1;
          wr_state           <= WRDATA;
        end
        WRDATA: begin
`ifdef AFU_CTRL_DCR_READY_EN
          // A DCR data write parks here with wready low until the device accepts it.
          if (w_hs) begin
            s_axi_ctrl_wready <= 1'b0;
            if (!wr_dcr_data) begin
              s_axi_ctrl_bvalid <= 1'b1;
              wr_state          <= WRRESP;
            end
          end else if (dcr_wr_valid && dcr_wr_ready) begin
            s_axi_ctrl_bvalid <= 1'b1;
            wr_state          <= WRRESP;
          end
`else
          if (w_hs) begin
            s_axi_ctrl_wready <= 1'b0;
            s_axi_ctrl_bvalid <= 1'b1;
            wr_state          <= WRRESP;
          end
`endif
        end
        WRRESP: if (s_axi_ctrl_bready) begin
          s_axi_ctrl_bvalid  <= 1'b0;
          s_axi_ctrl_awready <= 1'b1;
          wr_state           <= WRIDLE;
        end
        default: wr_state <= WRIDLE;
      endcase
    end
  end

  // Register file; all updates commit on the w handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done_bit     <= 1'b0;
      ready_bit    <= 1'b0;
      gie          <= 1'b0;
      ier          <= 2'b00;
      isr          <= 2'b00;
      interrupt    <= 1'b0;
      dcr_addr     <= '0;
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
    end else begin
      if (wr_ctrl && s_axi_ctrl_wstrb[0] && s_axi_ctrl_wdata[0]) ap_start <= 1'b1;
      else if (ap_ready && !auto_restart)                        ap_start <= 1'b0;
      if (wr_ctrl && s_axi_ctrl_wstrb[0]) auto_restart <= s_axi_ctrl_wdata[7];

      // Clear-on-read, but a pulse landing on the read itself survives to the next read.
      done_bit  <= ap_done  | (done_bit  & ~ctrl_rd);
      ready_bit <= ap_ready | (ready_bit & ~ctrl_rd);

      if (wr_gie && s_axi_ctrl_wstrb[0]) gie <= s_axi_ctrl_wdata[0];
      if (wr_ier && s_axi_ctrl_wstrb[0]) ier <= s_axi_ctrl_wdata[1:0];
      isr       <= isr_next;
      interrupt <= gie & (|isr_next);

      if (wr_dcr_addr) dcr_addr <= (dcr_addr & ~wmask) | (s_axi_ctrl_wdata & wmask);

      if (wr_dcr_data) begin
        dcr_wr_valid <= 1'b1;
        dcr_wr_addr  <= dcr_addr;
        dcr_wr_data  <= s_axi_ctrl_wdata;
      end else begin
`ifdef AFU_CTRL_DCR_READY_EN
        if (dcr_wr_ready) dcr_wr_valid <= 1'b0;
`else
        dcr_wr_valid <= 1'b0;
`endif
      end
    end
  end

  // NOTE: rd_mux gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rd_mux = '0;
    case (rd_word)
      A_CTRL:   rd_mux = {24'h0, auto_restart, 3'b000, ready_bit, ap_idle, done_bit, ap_start};
      A_GIE:    rd_mux = {31'h0, gie};
      A_IER:    rd_mux = {30'h0, ier};
      A_ISR:    rd_mux = {30'h0, isr};
      A_DEV_LO: rd_mux = DEV_CAPS[31:0];
      A_DEV_HI: rd_mux = DEV_CAPS[63:32];
      A_ISA_LO: rd_mux = ISA_CAPS[31:0];
      A_ISA_HI: rd_mux = ISA_CAPS[63:32];
      A_DCR_AD: rd_mux = dcr_addr;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state           <= RDRESET;
      s_axi_ctrl_arready <= 1'b0;
      s_axi_ctrl_rvalid  <= 1'b0;
      s_axi_ctrl_rdata   <= '0;
    end else begin
      case (rd_state)
        RDRESET: begin
          rd_state           <= RDIDLE;
          s_axi_ctrl_arready <= 1'b1;
        end
        RDIDLE: if (s_axi_ctrl_arvalid) begin
          s_axi_ctrl_rdata   <= rd_mux;
          s_axi_ctrl_rvalid  <= 1'b1;
          s_axi_ctrl_arready <= 1'b0;
          rd_state           <= RDDATA;
        end
        RDDATA: if (s_axi_ctrl_rready) begin
          s_axi_ctrl_rvalid  <= 1'b0;
          s_axi_ctrl_arready <= 1'b1;
          rd_state           <= RDIDLE;
        end
        default: rd_state <= RDIDLE;
      endcase
    end
  end

endmodule
